// File: rtl/gcd_arbiter_if.sv
// Signal bundle between gcd_arbiter and its surroundings: the requester
// side (req/operands/ack), the shared GCD engine side and the response side.
// The arbiter uses the slave modport; the environment uses master.
interface gcd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Requester side
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   ack;

    // Shared engine side
    logic              eng_go;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_b;
    logic              eng_done;
    logic [W-1:0]      eng_result;

    // Response side
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req, req_a, req_b, eng_done, eng_result,
        output ack, eng_go, eng_a, eng_b,
        output rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

    modport master (
        output req, req_a, req_b, eng_done, eng_result,
        input  ack, eng_go, eng_a, eng_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin front end for a single shared GCD engine.
// One request is served at a time: the winner's operands are captured,
// either answered directly (a zero operand makes the GCD trivial) or handed
// to the engine, and the result is returned as a one-cycle response pulse.
// A watchdog bounds the engine wait; an expired wait answers with an error.
// Reset is asynchronous active-low; its release is expected to be
// synchronised to clk outside this block.
module gcd_arbiter #(
    parameter int NREQ = 4,    // number of requesters, 2..8
    parameter int W    = 8,    // operand / result width
    parameter int TMO  = 1023  // engine wait limit in cycles, 1..1023
) (
    input  logic         clk,
    input  logic         rst,
    gcd_arbiter_if.slave bus
);

    localparam int             IDW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);
    // Last WAIT-cycle count value before the watchdog fires.
    localparam logic [9:0]     TMO_LAST = 10'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // First requester at or after the pointer, wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(p) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && r[IDW'(idx)]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Select one W-bit lane of a packed per-requester operand bus.
    function automatic logic [W-1:0] op_sel(input logic [NREQ*W-1:0] v,
                                            input logic [IDW-1:0]    sel);
        logic [W-1:0] o;
        o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                o = v[i*W +: W];
            end else begin
                o = o;
            end
        end
        return o;
    endfunction

    // Pointer value one past the given requester, wrapping at NREQ.
    function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] idx);
        logic [IDW-1:0] n;
        if (idx == ID_LAST) begin
            n = '0;
        end else begin
            n = idx + IDW'(1'b1);
        end
        return n;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // GCD when at least one operand is zero: the other operand (0 for 0,0).
    function automatic logic [W-1:0] zero_gcd(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] g;
        if (a == '0) begin
            g = b;
        end else begin
            g = a;
        end
        return g;
    endfunction

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          state_r;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  win_r;
    logic [NREQ-1:0] ack_r;
    logic            eng_go_r;
    logic [W-1:0]    eng_a_r;
    logic [W-1:0]    eng_b_r;
    logic            rsp_valid_r;
    logic [IDW-1:0]  rsp_id_r;
    logic [W-1:0]    rsp_result_r;
    logic            rsp_err_r;
    logic            busy_r;
    logic [9:0]      tmo_cnt_r;

    logic [IDW-1:0]  pick_s;
    logic [W-1:0]    op_a_s;
    logic [W-1:0]    op_b_s;
    logic            bypass_s;

    // Round-robin candidate and the current winner's operands.
    always_comb begin
        pick_s   = rr_pick(bus.req, ptr_r);
        op_a_s   = op_sel(bus.req_a, win_r);
        op_b_s   = op_sel(bus.req_b, win_r);
        bypass_s = (op_a_s == '0) || (op_b_s == '0);
    end

    // Transaction FSM; pulse outputs fall back to 0 unless re-asserted, and
    // every output is set on the edge entering the state that presents it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            win_r        <= '0;
            ack_r        <= '0;
            eng_go_r     <= 1'b0;
            eng_a_r      <= '0;
            eng_b_r      <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= '0;
            rsp_err_r    <= 1'b0;
            busy_r       <= 1'b0;
            tmo_cnt_r    <= 10'd0;
        end else begin
            ack_r       <= '0;
            eng_go_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Winner is frozen here; later req changes cannot move it.
                    if (bus.req != '0) begin
                        win_r   <= pick_s;
                        ack_r   <= onehot(pick_s);
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    // ack is high during this cycle; operands sampled at its end.
                    eng_a_r <= op_a_s;
                    eng_b_r <= op_b_s;
                    ptr_r   <= ptr_next(win_r);
                    busy_r  <= 1'b1;
                    if (bypass_s) begin
                        rsp_valid_r  <= 1'b1;
                        rsp_id_r     <= win_r;
                        rsp_result_r <= zero_gcd(op_a_s, op_b_s);
                        rsp_err_r    <= 1'b0;
                        state_r      <= RESP;
                    end else begin
                        eng_go_r <= 1'b1;
                        state_r  <= START;
                    end
                end
                START: begin
                    tmo_cnt_r <= 10'd0;
                    busy_r    <= 1'b1;
                    state_r   <= WAIT;
                end
                WAIT: begin
                    busy_r <= 1'b1;
                    // Completion wins over a watchdog expiring in the same cycle.
                    if (bus.eng_done) begin
                        rsp_valid_r  <= 1'b1;
                        rsp_id_r     <= win_r;
                        rsp_result_r <= bus.eng_result;
                        rsp_err_r    <= 1'b0;
                        state_r      <= RESP;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        rsp_valid_r  <= 1'b1;
                        rsp_id_r     <= win_r;
                        rsp_result_r <= '0;
                        rsp_err_r    <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 10'd1;
                        state_r   <= WAIT;
                    end
                end
                RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = ack_r;
    assign bus.eng_go     = eng_go_r;
    assign bus.eng_a      = eng_a_r;
    assign bus.eng_b      = eng_b_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.busy       = busy_r;

endmodule
